// File: rtl/button_decode.sv
// button_decode: front-panel pushbutton decoder.
// Synchronises and debounces an active-low mechanical button, then classifies
// each gesture as a short, double or long press, reported as one-clock pulses.
module button_decode #(
    parameter int clock_speed = 25000000,
    parameter int DEBOUNCE    = clock_speed / 100,
    parameter int LONG        = clock_speed,
    parameter int GAP         = (clock_speed / 10) * 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
    output logic pressed,
    output logic short_press,
    output logic double_press,
    output logic long_press
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DOWN1 = 2'd1,
        UP1   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    logic        sync1;
    logic        sync2;
    logic        db_state;      // debounced level, 1 = released
    logic [31:0] db_count;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] timer;
    logic [31:0] timer_nxt;
    logic        short_nxt;
    logic        double_nxt;
    logic        long_nxt;

    // Two-flop synchroniser for the asynchronous pin; idles released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button_n;
            sync2 <= sync1;
        end
    end

    // Debouncer: DEBOUNCE consecutive disagreeing samples toggle the level;
    // the registered pressed output adds one cycle so the rise lands
    // DEBOUNCE+2 edges after the first low sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_state <= 1'b1;
            db_count <= '0;
            pressed  <= 1'b0;
        end else begin
            if (sync2 != db_state) begin
                if (db_count == 32'(DEBOUNCE - 1)) begin
                    db_state <= ~db_state;
                    db_count <= '0;
                end else begin
                    db_count <= db_count + 32'd1;
                end
            end else begin
                db_count <= '0;
            end
            pressed <= ~db_state;
        end
    end

    // Gesture state, shared event timer and registered event pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            short_press  <= short_nxt;
            double_press <= double_nxt;
            long_press   <= long_nxt;
        end
    end

    // Next-state logic. DOWN1 is entered one cycle after pressed rises, so
    // reaching LONG from the rise means the timer has counted LONG-2; UP1 is
    // entered one cycle after the fall and short fires GAP+1 after it, i.e.
    // at timer GAP-1. Level changes take priority over timer expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pressed) state_nxt = DOWN1;
            end
            DOWN1: begin
                if (!pressed)                        state_nxt = UP1;
                else if (timer == 32'(LONG - 2))     state_nxt = HOLD;
            end
            UP1: begin
                if (pressed)                         state_nxt = HOLD;
                else if (timer == 32'(GAP - 1))      state_nxt = IDLE;
            end
            HOLD: begin
                if (!pressed) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Timer restarts on every state entry and only runs in timed states.
        timer_nxt = '0;
        if (state_nxt == state && (state == DOWN1 || state == UP1))
            timer_nxt = timer + 32'd1;
    end

    // Event decode: each pulse is tied to exactly one exclusive transition.
    always_comb begin
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        case (state)
            DOWN1: long_nxt = pressed && (timer == 32'(LONG - 2));
            UP1: begin
                double_nxt = pressed;
                short_nxt  = !pressed && (timer == 32'(GAP - 1));
            end
            default: ;
        endcase
    end

endmodule
